pipelined_control_unit: RTL and testbench
=========================================

Name: pipelined_control_unit

Overview:
Next-generation main decoder for the pipelined RV32I core. It decodes the opcode in Decode (D) and carries the control bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers, with stall and flush handling. Every opcode, including unknown ones, produces defined outputs. It adds optional U-type support (lui/auipc), an illegal-opcode flag and a retired-instruction counter. It replaces the purely combinational decoder plus the hand-copied control pipeline registers in the datapath.

Parameters:
U_EXT, 1, 1 = decode lui/auipc; 0 = treat them as illegal
CNT_W, 32, width of the retired-instruction counter (minimum 4)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  synchronous active-low reset
op_d  in  7  opcode of the instruction in D
valid_d  in  1  D holds a real instruction
stall_e  in  1  hold the ID/EX register
flush_e  in  1  load a bubble into ID/EX
immsrc_d  out  3  combinational: 000 I, 001 S, 010 B, 011 J, 100 U
regwr_e, memwr_e, branch_e, jump_e, jalr_e, alusrc_e  out  1 each  EX-stage controls
alusrca_e  out  2  00 rs1, 01 PC, 10 zero
aluop_e  out  2  to the ALU decoder
resultsrc_e  out  2  00 ALU, 01 mem, 10 PC+4
regwr_m, memwr_m  out  1 each  MEM-stage controls
resultsrc_m  out  2  MEM-stage result select
regwr_w  out  1  WB-stage register write
resultsrc_w  out  2  WB-stage result select
valid_w  out  1  WB holds a real instruction
illegal_w  out  1  WB instruction had an illegal opcode
illegal_seen  out  1  sticky illegal flag
retired_cnt  out  CNT_W  instructions retired

Behaviour:
- Reset: on a clk edge with rst_n=0, every registered output, all internal valid/illegal bits, illegal_seen and retired_cnt go to 0. This applies equally mid-operation, and reset has priority over stall and flush.
- Decode (combinational, no x values). Fields are regwr / immsrc / alusrc / alusrca / memwr / resultsrc / branch / aluop / jump / jalr.
  - lw 0000011: 1 / 000 / 1 / 00 / 0 / 01 / 0 / 00 / 0 / 0
  - sw 0100011: 0 / 001 / 1 / 00 / 1 / 00 / 0 / 00 / 0 / 0
  - R 0110011: 1 / 000 / 0 / 00 / 0 / 00 / 0 / 10 / 0 / 0
  - B 1100011: 0 / 010 / 0 / 00 / 0 / 00 / 1 / 01 / 0 / 0
  - I-alu 0010011: 1 / 000 / 1 / 00 / 0 / 00 / 0 / 10 / 0 / 0
  - jal 1101111: 1 / 011 / 0 / 00 / 0 / 10 / 0 / 00 / 1 / 0
  - jalr 1100111: 1 / 000 / 1 / 00 / 0 / 10 / 0 / 00 / 0 / 1
  - lui 0110111 (U_EXT=1 only): 1 / 100 / 1 / 10 / 0 / 00 / 0 / 00 / 0 / 0
  - auipc 0010111 (U_EXT=1 only): 1 / 100 / 1 / 01 / 0 / 00 / 0 / 00 / 0 / 0
  - Any other opcode: all fields 0, illegal=1.
- Bubble: all controls 0, valid=0, illegal=0. A valid_d=0 instruction is loaded as a bubble.
- ID/EX update, in priority order:
  - flush_e: load a bubble.
  - else stall_e: hold the current contents.
  - else: load the decoded bundle with valid=valid_d and illegal=illegal&valid_d.
- EX/MEM update:
  - If stall_e=1 and flush_e=0, EX/MEM loads a bubble, so a held instruction is never duplicated.
  - Otherwise EX/MEM loads the ID/EX contents.
- MEM/WB: always loads the EX/MEM contents.
- Latency: D to E is 1 cycle, D to M is 2 cycles, D to W is 3 cycles when no stall or flush occurs.
- Illegal handling: an illegal instruction has regwr=0 and memwr=0 in every stage and cannot corrupt state. When valid_w & illegal_w, illegal_seen sets on the next edge and stays set until reset.
- retired_cnt: increments by 1 on each edge where valid_w=1 and illegal_w=0. It saturates at 2^CNT_W-1 and never wraps.
- Simultaneous stall_e and flush_e: flush wins, so ID/EX becomes a bubble and EX/MEM loads the old ID/EX contents.

Test Plan:
- Reset check: assert rst_n=0 for 2 cycles mid-stream -> all registered outputs, illegal_seen and retired_cnt are 0 on the next edge.
- Opcode sweep: sequence lw, sw, R, B, I, jal, jalr, lui, auipc with valid_d=1 -> each table row appears on the *_e outputs one cycle later. The matching regwr_w/resultsrc_w appear 3 cycles later. retired_cnt reaches 9.
- U_EXT=0 build: drive lui (0110111) -> all controls 0 and illegal_w=1 at W. illegal_seen=1 one cycle after that. retired_cnt is unchanged.
- Stall: lw in E with stall_e=1 for 2 cycles -> resultsrc_e holds 01, memwr_m=0 and regwr_m=0 during the stall, and lw reaches W exactly once.
- Flush plus stall: drive R-type with flush_e=1 and stall_e=1 together -> regwr_e=0 next cycle, and the prior E contents advance to M.
- Counter saturation: CNT_W=4, stream 20 valid R-types -> retired_cnt stops at 15.

Source files
------------

// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit
//   Main decoder for the pipelined RV32I core. Decodes the opcode in D and
//   carries the control bundle through ID/EX, EX/MEM and MEM/WB, with stall
//   and flush handling, an illegal-opcode flag and a retired-instruction
//   counter.
//
// Ports
//   clk, rst_n          core clock (rising edge), synchronous active-low reset
//   op_d, valid_d       opcode of the D instruction and its valid qualifier
//   stall_e, flush_e    hold / bubble the ID/EX register
//   immsrc_d            combinational immediate select for D
//   *_e                 EX-stage controls
//   *_m                 MEM-stage controls
//   *_w, valid_w        WB-stage controls and qualifiers
//   illegal_seen        sticky flag, set once an illegal instruction retires
//   retired_cnt         saturating count of legal instructions retired

module pipelined_control_unit #(
  parameter int U_EXT = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op_d,
  input  logic             valid_d,
  input  logic             stall_e,
  input  logic             flush_e,
  output logic [2:0]       immsrc_d,
  output logic             regwr_e,
  output logic             memwr_e,
  output logic             branch_e,
  output logic             jump_e,
  output logic             jalr_e,
  output logic             alusrc_e,
  output logic [1:0]       alusrca_e,
  output logic [1:0]       aluop_e,
  output logic [1:0]       resultsrc_e,
  output logic             regwr_m,
  output logic             memwr_m,
  output logic [1:0]       resultsrc_m,
  output logic             regwr_w,
  output logic [1:0]       resultsrc_w,
  output logic             valid_w,
  output logic             illegal_w,
  output logic             illegal_seen,
  output logic [CNT_W-1:0] retired_cnt
);

  logic       w_regwr, w_alusrc, w_memwr, w_branch, w_jump, w_jalr, w_illegal;
  logic [1:0] w_alusrca, w_resultsrc, w_aluop;
  logic [2:0] w_immsrc;

  always_comb begin
    w_regwr     = 1'b0;
    w_immsrc    = 3'b000;
    w_alusrc    = 1'b0;
    w_alusrca   = 2'b00;
    w_memwr     = 1'b0;
    w_resultsrc = 2'b00;
    w_branch    = 1'b0;
    w_aluop     = 2'b00;
    w_jump      = 1'b0;
    w_jalr      = 1'b0;
    w_illegal   = 1'b0;
    case (op_d)
      7'b0000011: begin w_regwr = 1'b1; w_alusrc = 1'b1; w_resultsrc = 2'b01; end
      7'b0100011: begin w_immsrc = 3'b001; w_alusrc = 1'b1; w_memwr = 1'b1; end
      7'b0110011: begin w_regwr = 1'b1; w_aluop = 2'b10; end
      7'b1100011: begin w_immsrc = 3'b010; w_branch = 1'b1; w_aluop = 2'b01; end
      7'b0010011: begin w_regwr = 1'b1; w_alusrc = 1'b1; w_aluop = 2'b10; end
      7'b1101111: begin w_regwr = 1'b1; w_immsrc = 3'b011; w_resultsrc = 2'b10; w_jump = 1'b1; end
      7'b1100111: begin w_regwr = 1'b1; w_alusrc = 1'b1; w_resultsrc = 2'b10; w_jalr = 1'b1; end
      7'b0110111: begin
        if (U_EXT != 0) begin
          w_regwr = 1'b1; w_immsrc = 3'b100; w_alusrc = 1'b1; w_alusrca = 2'b10;
        end else begin
          w_illegal = 1'b1;
        end
      end
      7'b0010111: begin
        if (U_EXT != 0) begin
          w_regwr = 1'b1; w_immsrc = 3'b100; w_alusrc = 1'b1; w_alusrca = 2'b01;
        end else begin
          w_illegal = 1'b1;
        end
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign immsrc_d = w_immsrc;

  // ID/EX
  logic       r_regwr_e, r_memwr_e, r_branch_e, r_jump_e, r_jalr_e, r_alusrc_e;
  logic       r_valid_e, r_illegal_e;
  logic [1:0] r_alusrca_e, r_aluop_e, r_resultsrc_e;

  // An invalid D slot enters as a bubble, so every field is gated by valid_d.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_e) begin
      r_regwr_e     <= 1'b0;
      r_memwr_e     <= 1'b0;
      r_branch_e    <= 1'b0;
      r_jump_e      <= 1'b0;
      r_jalr_e      <= 1'b0;
      r_alusrc_e    <= 1'b0;
      r_alusrca_e   <= 2'b00;
      r_aluop_e     <= 2'b00;
      r_resultsrc_e <= 2'b00;
      r_valid_e     <= 1'b0;
      r_illegal_e   <= 1'b0;
    end else if (!stall_e) begin
      r_regwr_e     <= w_regwr & valid_d;
      r_memwr_e     <= w_memwr & valid_d;
      r_branch_e    <= w_branch & valid_d;
      r_jump_e      <= w_jump & valid_d;
      r_jalr_e      <= w_jalr & valid_d;
      r_alusrc_e    <= w_alusrc & valid_d;
      r_alusrca_e   <= w_alusrca & {2{valid_d}};
      r_aluop_e     <= w_aluop & {2{valid_d}};
      r_resultsrc_e <= w_resultsrc & {2{valid_d}};
      r_valid_e     <= valid_d;
      r_illegal_e   <= w_illegal & valid_d;
    end
  end

  // EX/MEM: a stalled E instruction stays in E, so MEM takes a bubble
  // rather than a second copy of it.
  logic       r_regwr_m, r_memwr_m, r_valid_m, r_illegal_m;
  logic [1:0] r_resultsrc_m;

  always_ff @(posedge clk) begin
    if (!rst_n || (stall_e && !flush_e)) begin
      r_regwr_m     <= 1'b0;
      r_memwr_m     <= 1'b0;
      r_resultsrc_m <= 2'b00;
      r_valid_m     <= 1'b0;
      r_illegal_m   <= 1'b0;
    end else begin
      r_regwr_m     <= r_regwr_e;
      r_memwr_m     <= r_memwr_e;
      r_resultsrc_m <= r_resultsrc_e;
      r_valid_m     <= r_valid_e;
      r_illegal_m   <= r_illegal_e;
    end
  end

  // MEM/WB
  logic       r_regwr_w, r_valid_w, r_illegal_w;
  logic [1:0] r_resultsrc_w;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_regwr_w     <= 1'b0;
      r_resultsrc_w <= 2'b00;
      r_valid_w     <= 1'b0;
      r_illegal_w   <= 1'b0;
    end else begin
      r_regwr_w     <= r_regwr_m;
      r_resultsrc_w <= r_resultsrc_m;
      r_valid_w     <= r_valid_m;
      r_illegal_w   <= r_illegal_m;
    end
  end

  // Retirement status
  logic             r_illegal_seen;
  logic [CNT_W-1:0] r_retired_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_illegal_seen <= 1'b0;
      r_retired_cnt  <= '0;
    end else begin
      if (r_valid_w && r_illegal_w)
        r_illegal_seen <= 1'b1;
      if (r_valid_w && !r_illegal_w && (r_retired_cnt != {CNT_W{1'b1}}))
        r_retired_cnt <= r_retired_cnt + CNT_W'(1);
    end
  end

  assign regwr_e      = r_regwr_e;
  assign memwr_e      = r_memwr_e;
  assign branch_e     = r_branch_e;
  assign jump_e       = r_jump_e;
  assign jalr_e       = r_jalr_e;
  assign alusrc_e     = r_alusrc_e;
  assign alusrca_e    = r_alusrca_e;
  assign aluop_e      = r_aluop_e;
  assign resultsrc_e  = r_resultsrc_e;
  assign regwr_m      = r_regwr_m;
  assign memwr_m      = r_memwr_m;
  assign resultsrc_m  = r_resultsrc_m;
  assign regwr_w      = r_regwr_w;
  assign resultsrc_w  = r_resultsrc_w;
  assign valid_w      = r_valid_w;
  assign illegal_w    = r_illegal_w;
  assign illegal_seen = r_illegal_seen;
  assign retired_cnt  = r_retired_cnt;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit. Instance a: U_EXT=1, CNT_W=4.
// Instance b: U_EXT=0, CNT_W=8. Both share the same stimulus.
// WB results are queued at issue and popped by a monitor when valid_w rises.

module tb_pipelined_control_unit;

  logic       clk = 1'b0;
  logic       rst_n, valid_d, stall_e, flush_e;
  logic [6:0] op_d;

  always #5 clk = ~clk;

  logic [2:0] a_immsrc_d, b_immsrc_d;
  logic       a_regwr_e, a_memwr_e, a_branch_e, a_jump_e, a_jalr_e, a_alusrc_e;
  logic       b_regwr_e, b_memwr_e, b_branch_e, b_jump_e, b_jalr_e, b_alusrc_e;
  logic [1:0] a_alusrca_e, a_aluop_e, a_resultsrc_e, b_alusrca_e, b_aluop_e, b_resultsrc_e;
  logic       a_regwr_m, a_memwr_m, b_regwr_m, b_memwr_m;
  logic [1:0] a_resultsrc_m, b_resultsrc_m;
  logic       a_regwr_w, a_valid_w, a_illegal_w, a_illegal_seen;
  logic       b_regwr_w, b_valid_w, b_illegal_w, b_illegal_seen;
  logic [1:0] a_resultsrc_w, b_resultsrc_w;
  logic [3:0] a_retired_cnt;
  logic [7:0] b_retired_cnt;

  pipelined_control_unit #(.U_EXT(1), .CNT_W(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .op_d(op_d), .valid_d(valid_d),
    .stall_e(stall_e), .flush_e(flush_e), .immsrc_d(a_immsrc_d),
    .regwr_e(a_regwr_e), .memwr_e(a_memwr_e), .branch_e(a_branch_e),
    .jump_e(a_jump_e), .jalr_e(a_jalr_e), .alusrc_e(a_alusrc_e),
    .alusrca_e(a_alusrca_e), .aluop_e(a_aluop_e), .resultsrc_e(a_resultsrc_e),
    .regwr_m(a_regwr_m), .memwr_m(a_memwr_m), .resultsrc_m(a_resultsrc_m),
    .regwr_w(a_regwr_w), .resultsrc_w(a_resultsrc_w), .valid_w(a_valid_w),
    .illegal_w(a_illegal_w), .illegal_seen(a_illegal_seen), .retired_cnt(a_retired_cnt)
  );

  pipelined_control_unit #(.U_EXT(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .op_d(op_d), .valid_d(valid_d),
    .stall_e(stall_e), .flush_e(flush_e), .immsrc_d(b_immsrc_d),
    .regwr_e(b_regwr_e), .memwr_e(b_memwr_e), .branch_e(b_branch_e),
    .jump_e(b_jump_e), .jalr_e(b_jalr_e), .alusrc_e(b_alusrc_e),
    .alusrca_e(b_alusrca_e), .aluop_e(b_aluop_e), .resultsrc_e(b_resultsrc_e),
    .regwr_m(b_regwr_m), .memwr_m(b_memwr_m), .resultsrc_m(b_resultsrc_m),
    .regwr_w(b_regwr_w), .resultsrc_w(b_resultsrc_w), .valid_w(b_valid_w),
    .illegal_w(b_illegal_w), .illegal_seen(b_illegal_seen), .retired_cnt(b_retired_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard entries: {regwr_w, resultsrc_w[1:0], illegal_w}
  logic [3:0] q_a[$];
  logic [3:0] q_b[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Field order: regwr, immsrc[2:0], alusrc, alusrca[1:0], memwr,
  // resultsrc[1:0], branch, aluop[1:0], jump, jalr (immsrc slot zeroed here).
  function automatic logic [14:0] ev_a();
    return {a_regwr_e, 3'b000, a_alusrc_e, a_alusrca_e, a_memwr_e, a_resultsrc_e,
            a_branch_e, a_aluop_e, a_jump_e, a_jalr_e};
  endfunction

  function automatic logic [14:0] ev_b();
    return {b_regwr_e, 3'b000, b_alusrc_e, b_alusrca_e, b_memwr_e, b_resultsrc_e,
            b_branch_e, b_aluop_e, b_jump_e, b_jalr_e};
  endfunction

  localparam logic [14:0] NO_IMM = 15'b1_000_1_11_1_11_1_11_1_1;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (a_valid_w) begin
        if (q_a.size() == 0) chk("a_w_unexpected", 32'd1, 32'd0);
        else chk("a_w_bundle", {28'd0, a_regwr_w, a_resultsrc_w, a_illegal_w}, {28'd0, q_a.pop_front()});
      end
      if (b_valid_w) begin
        if (q_b.size() == 0) chk("b_w_unexpected", 32'd1, 32'd0);
        else chk("b_w_bundle", {28'd0, b_regwr_w, b_resultsrc_w, b_illegal_w}, {28'd0, q_b.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    valid_d = 1'b0;
    stall_e = 1'b0;
    flush_e = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic push_r();
    q_a.push_back(4'b1_00_0);
    q_b.push_back(4'b1_00_0);
  endtask

  logic [6:0]  ops  [9];
  logic [14:0] rows [9];

  initial begin
    ops  = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011,
             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    rows = '{15'b1_000_1_00_0_01_0_00_0_0,   // lw
             15'b0_001_1_00_1_00_0_00_0_0,   // sw
             15'b1_000_0_00_0_00_0_10_0_0,   // R
             15'b0_010_0_00_0_00_1_01_0_0,   // B
             15'b1_000_1_00_0_00_0_10_0_0,   // I-alu
             15'b1_011_0_00_0_10_0_00_1_0,   // jal
             15'b1_000_1_00_0_10_0_00_0_1,   // jalr
             15'b1_100_1_10_0_00_0_00_0_0,   // lui
             15'b1_100_1_01_0_00_0_00_0_0};  // auipc

    rst_n = 1'b0; valid_d = 1'b0; stall_e = 1'b0; flush_e = 1'b0; op_d = 7'b0110011;
    tick();
    tick();
    chk("reset_a_regs", {17'd0, ev_a(), a_regwr_m, a_memwr_m, a_resultsrc_m, a_regwr_w,
        a_resultsrc_w, a_valid_w, a_illegal_w, a_illegal_seen, a_retired_cnt}, 32'd0);
    chk("reset_b_cnt", {24'd0, b_retired_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Opcode sweep
    for (int i = 0; i < 9; i++) begin
      op_d = ops[i];
      valid_d = 1'b1;
      #1;
      chk($sformatf("a_immsrc_d[%0d]", i), {29'd0, a_immsrc_d}, {29'd0, rows[i][13:11]});
      chk($sformatf("b_immsrc_d[%0d]", i), {29'd0, b_immsrc_d}, (i >= 7) ? 32'd0 : {29'd0, rows[i][13:11]});
      q_a.push_back({rows[i][14], rows[i][6:5], 1'b0});
      q_b.push_back((i >= 7) ? 4'b0_00_1 : {rows[i][14], rows[i][6:5], 1'b0});
      tick();
      chk($sformatf("a_ctrl_e[%0d]", i), {17'd0, ev_a()}, {17'd0, rows[i] & NO_IMM});
      chk($sformatf("b_ctrl_e[%0d]", i), {17'd0, ev_b()}, (i >= 7) ? 32'd0 : {17'd0, rows[i] & NO_IMM});
    end
    drain(3);
    chk("a_cnt_sweep", {28'd0, a_retired_cnt}, 32'd9);
    chk("b_cnt_sweep", {24'd0, b_retired_cnt}, 32'd7);
    chk("a_seen_sweep", {31'd0, a_illegal_seen}, 32'd0);
    chk("b_seen_sweep", {31'd0, b_illegal_seen}, 32'd1);

    // Unknown opcode
    op_d = 7'b1111111; valid_d = 1'b1;
    q_a.push_back(4'b0_00_1);
    q_b.push_back(4'b0_00_1);
    tick();
    chk("a_unknown_e", {17'd0, ev_a()}, 32'd0);
    drain(3);
    chk("a_seen_unknown", {31'd0, a_illegal_seen}, 32'd1);
    chk("a_cnt_unknown", {28'd0, a_retired_cnt}, 32'd9);

    // Stall: lw held in E for two cycles
    op_d = 7'b0000011; valid_d = 1'b1;
    q_a.push_back(4'b1_01_0);
    q_b.push_back(4'b1_01_0);
    tick();
    op_d = 7'b0110011; stall_e = 1'b1;
    for (int s = 0; s < 2; s++) begin
      tick();
      chk("stall_resultsrc_e", {30'd0, a_resultsrc_e}, 32'd1);
      chk("stall_regwr_m", {31'd0, a_regwr_m}, 32'd0);
      chk("stall_memwr_m", {31'd0, a_memwr_m}, 32'd0);
    end
    stall_e = 1'b0;
    push_r();
    tick();
    chk("unstall_m", {29'd0, a_regwr_m, a_resultsrc_m}, 32'b101);
    chk("unstall_e", {29'd0, a_regwr_e, a_resultsrc_e}, 32'b100);
    drain(3);
    chk("a_cnt_stall", {28'd0, a_retired_cnt}, 32'd11);

    // Flush and stall together: sw in E advances, R is dropped
    op_d = 7'b0100011; valid_d = 1'b1;
    q_a.push_back(4'b0_00_0);
    q_b.push_back(4'b0_00_0);
    tick();
    op_d = 7'b0110011; stall_e = 1'b1; flush_e = 1'b1;
    tick();
    chk("flush_regwr_e", {31'd0, a_regwr_e}, 32'd0);
    chk("flush_memwr_e", {31'd0, a_memwr_e}, 32'd0);
    chk("flush_memwr_m", {31'd0, a_memwr_m}, 32'd1);
    drain(3);
    chk("a_cnt_flush", {28'd0, a_retired_cnt}, 32'd12);
    chk("b_cnt_flush", {24'd0, b_retired_cnt}, 32'd10);

    // Counter saturation
    op_d = 7'b0110011; valid_d = 1'b1;
    for (int r = 0; r < 20; r++) begin
      push_r();
      tick();
    end
    drain(3);
    chk("a_cnt_sat", {28'd0, a_retired_cnt}, 32'd15);
    chk("b_cnt_stream", {24'd0, b_retired_cnt}, 32'd30);

    // Reset mid-stream: the two in-flight R-types must never retire
    op_d = 7'b0110011; valid_d = 1'b1;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_a_regs", {17'd0, ev_a(), a_regwr_m, a_memwr_m, a_resultsrc_m, a_regwr_w,
        a_resultsrc_w, a_valid_w, a_illegal_w, a_illegal_seen, a_retired_cnt}, 32'd0);
    chk("midrst_b_cnt", {24'd0, b_retired_cnt}, 32'd0);
    chk("midrst_b_seen", {31'd0, b_illegal_seen}, 32'd0);
    tick();
    rst_n = 1'b1;
    drain(5);
    chk("a_cnt_after_rst", {28'd0, a_retired_cnt}, 32'd0);
    chk("q_a_empty", q_a.size(), 32'd0);
    chk("q_b_empty", q_b.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
